bemf_accum_nch: RTL and testbench

//   Next-generation back-EMF integrator. Time-multiplexed over NUM_MOT motors and parametrised in width.

---
 rtl/bemf_pkg.sv | 28 ++
 rtl/bemf_sat_add.sv | 33 +++
 rtl/bemf_accum_nch.sv | 156 +++++++++++++++
 tb/tb_bemf_accum_nch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bemf_pkg.sv
// Shared definitions for the back-EMF integrator.
//   sel_w()   : channel-select width for a given motor count (never below 1)
//   acc_max() : most positive value of a w-bit signed word
//   acc_min() : most negative value of a w-bit signed word
//   *_DEF     : default widths and deadband thresholds
package bemf_pkg;

  localparam int NUM_MOT_DEF = 4;
  localparam int ADC_W_DEF   = 10;
  localparam int ACC_W_DEF   = 20;
  localparam int DB_POS_DEF  = 20;
  localparam int DB_NEG_DEF  = 22;

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic longint acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/bemf_sat_add.sv
// Signed W-bit adder that clamps to the representable range.
//   a, b : signed addends
//   sum  : a+b, clamped to [acc_min(W), acc_max(W)]
//   sat  : 1 when the clamp was applied
module bemf_sat_add
  import bemf_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  localparam logic signed [W-1:0] MAXV = W'(acc_max(W));
  localparam logic signed [W-1:0] MINV = W'(acc_min(W));

  logic signed [W:0] wide;

  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    sum  = wide[W-1:0];
    sat  = 1'b0;
    // Overflow shows up as a mismatch between the extra sign bit and the
    // top bit of the W-bit result; the extra bit tells us which direction.
    if (wide[W] != wide[W-1]) begin
      sat = 1'b1;
      sum = wide[W] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/bemf_accum_nch.sv
// Time-multiplexed back-EMF integrator for NUM_MOT motors.
// Four register stages: S0 input capture, S1 h-l difference,
// S2 calibration offset + deadband, S3 saturating accumulate and outputs.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bemf_adc_h/l, mot_sel_in   sample and its channel; in_valid strobes it
//   cal_we, cal_sel, cal_data  calibration word write
//   acc_clr                    per-channel accumulator clear (multi-hot)
//   bemf_out                   updated accumulator (position)
//   bemf_vel_out               deadbanded calibrated sample (velocity)
//   mot_sel_out, sat_out       channel of outputs, clamp flag
//   out_valid                  one-cycle pulse per accepted sample
module bemf_accum_nch
  import bemf_pkg::*;
#(
  parameter int NUM_MOT = NUM_MOT_DEF,
  parameter int ADC_W   = ADC_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DB_POS  = DB_POS_DEF,
  parameter int DB_NEG  = DB_NEG_DEF,
  localparam int SEL_W  = sel_w(NUM_MOT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADC_W-1:0]        bemf_adc_h,
  input  logic [ADC_W-1:0]        bemf_adc_l,
  input  logic [SEL_W-1:0]        mot_sel_in,
  input  logic                    in_valid,
  input  logic                    cal_we,
  input  logic [SEL_W-1:0]        cal_sel,
  input  logic [ACC_W-1:0]        cal_data,
  input  logic [NUM_MOT-1:0]      acc_clr,
  output logic signed [ACC_W-1:0] bemf_out,
  output logic signed [ACC_W-1:0] bemf_vel_out,
  output logic [SEL_W-1:0]        mot_sel_out,
  output logic                    sat_out,
  output logic                    out_valid
);

  localparam logic signed [ACC_W-1:0] DBP = ACC_W'(DB_POS);
  localparam logic signed [ACC_W-1:0] DBN = ACC_W'(-DB_NEG);

  // Per-channel register files.
  logic signed [ACC_W-1:0] acc   [NUM_MOT];
  logic signed [ACC_W-1:0] calib [NUM_MOT];

  // Pipeline state.
  logic                    s0_valid;
  logic [ADC_W-1:0]        s0_h, s0_l;
  logic [SEL_W-1:0]        s0_ch;
  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_diff;
  logic [SEL_W-1:0]        s1_ch;
  logic                    s2_valid;
  logic signed [ACC_W-1:0] s2_vel;
  logic [SEL_W-1:0]        s2_ch;

  // Out-of-range channels are filtered at the door so no later stage can
  // index past the register files.
  logic in_ok, cal_ok;
  assign in_ok  = in_valid && (int'(mot_sel_in) < NUM_MOT);
  assign cal_ok = cal_we && (int'(cal_sel) < NUM_MOT);

  // S2 combinational: calibration and deadband.
  logic signed [ACC_W-1:0] cal_val, vel_val;
  always_comb begin
    cal_val = s1_diff - calib[s1_ch];
    vel_val = ((cal_val > DBP) || (cal_val < DBN)) ? cal_val : '0;
  end

  // S3 combinational: read-modify-write of the channel accumulator. Because
  // the read and write both happen here, consecutive samples on one channel
  // chain naturally without forwarding.
  logic signed [ACC_W-1:0] acc_cur, acc_sum;
  logic                    acc_sat, s3_clr;
  assign acc_cur = acc[s2_ch];
  assign s3_clr  = acc_clr[s2_ch];

  bemf_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_cur),
    .b   (s2_vel),
    .sum (acc_sum),
    .sat (acc_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_h     <= '0;
      s0_l     <= '0;
      s0_ch    <= '0;
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_vel   <= '0;
      s2_ch    <= '0;
    end else begin
      s0_valid <= in_ok;
      s0_h     <= bemf_adc_h;
      s0_l     <= bemf_adc_l;
      s0_ch    <= mot_sel_in;
      s1_valid <= s0_valid;
      s1_diff  <= $signed(ACC_W'(s0_h)) - $signed(ACC_W'(s0_l));
      s1_ch    <= s0_ch;
      s2_valid <= s1_valid;
      s2_vel   <= vel_val;
      s2_ch    <= s1_ch;
    end
  end

  // Outputs hold through bubbles; a clear on the S3 channel forces the
  // position result to zero but the velocity still reports the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      bemf_out     <= '0;
      bemf_vel_out <= '0;
      mot_sel_out  <= '0;
      sat_out      <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        mot_sel_out  <= s2_ch;
        bemf_vel_out <= s2_vel;
        if (s3_clr) begin
          bemf_out <= '0;
          sat_out  <= 1'b0;
        end else begin
          bemf_out <= acc_sum;
          sat_out  <= acc_sat;
        end
      end
    end
  end

  // Register files: clear beats the S3 write-back of the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MOT; k++) begin
        acc[k]   <= '0;
        calib[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_MOT; k++) begin
        if (acc_clr[k])
          acc[k] <= '0;
        else if (s2_valid && (s2_ch == SEL_W'(k)))
          acc[k] <= acc_sum;
        if (cal_ok && (cal_sel == SEL_W'(k)))
          calib[k] <= cal_data;
      end
    end
  end

endmodule

// File: tb/tb_bemf_accum_nch.sv
// Self-checking bench for bemf_accum_nch (default parameters).
// A behavioural model tracks samples by the edge on which they were accepted
// and resolves each one from the block's arithmetic rules; outputs are
// compared against it on every cycle, and directed scenarios pin literals.
module tb_bemf_accum_nch;

  localparam int  NUM_MOT = 4;
  localparam int  ADC_W   = 10;
  localparam int  ACC_W   = 20;
  localparam int  SEL_W   = 2;
  localparam longint AMAX = 524287;
  localparam longint AMIN = -524288;

  logic                    clk;
  logic                    rst_n;
  logic [ADC_W-1:0]        bemf_adc_h, bemf_adc_l;
  logic [SEL_W-1:0]        mot_sel_in;
  logic                    in_valid;
  logic                    cal_we;
  logic [SEL_W-1:0]        cal_sel;
  logic [ACC_W-1:0]        cal_data;
  logic [NUM_MOT-1:0]      acc_clr;
  logic signed [ACC_W-1:0] bemf_out, bemf_vel_out;
  logic [SEL_W-1:0]        mot_sel_out;
  logic                    sat_out, out_valid;

  bemf_accum_nch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bemf_adc_h   (bemf_adc_h),
    .bemf_adc_l   (bemf_adc_l),
    .mot_sel_in   (mot_sel_in),
    .in_valid     (in_valid),
    .cal_we       (cal_we),
    .cal_sel      (cal_sel),
    .cal_data     (cal_data),
    .acc_clr      (acc_clr),
    .bemf_out     (bemf_out),
    .bemf_vel_out (bemf_vel_out),
    .mot_sel_out  (mot_sel_out),
    .sat_out      (sat_out),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint diff;
    longint vel;
    int     edge_n;
  } samp_t;

  samp_t  q[$];
  longint acc_m [NUM_MOT];
  longint cal_m [NUM_MOT];
  int     edge_cnt;
  logic   m_valid;
  longint m_out, m_vel;
  int     m_sel;
  logic   m_sat;
  int     checks, errors;

  function automatic longint sx(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < NUM_MOT; k++) begin
      acc_m[k] = 0;
      cal_m[k] = 0;
    end
    edge_cnt = 0;
    m_valid = 0; m_out = 0; m_vel = 0; m_sel = 0; m_sat = 0;
  endtask

  // Called exactly at a rising edge, before the bench changes inputs.
  // A sample accepted on edge t reads calibration on edge t+2 (before that
  // edge's write) and updates its accumulator on edge t+3.
  task automatic model_edge();
    samp_t  e;
    longint c, s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_cnt++;
    m_valid = 0;
    if (q.size() > 0 && q[0].edge_n == edge_cnt - 3) begin
      e = q.pop_front();
      m_valid = 1;
      m_sel   = e.ch;
      m_vel   = e.vel;
      if (acc_clr[e.ch]) begin
        m_out = 0;
        m_sat = 0;
      end else begin
        s = acc_m[e.ch] + e.vel;
        m_sat = (s > AMAX) || (s < AMIN);
        if (s > AMAX) s = AMAX;
        if (s < AMIN) s = AMIN;
        acc_m[e.ch] = s;
        m_out = s;
      end
    end
    for (int k = 0; k < NUM_MOT; k++)
      if (acc_clr[k]) acc_m[k] = 0;
    foreach (q[i]) begin
      if (q[i].edge_n == edge_cnt - 2) begin
        c = q[i].diff - cal_m[q[i].ch];
        q[i].vel = (c > 20 || c < -22) ? c : 0;
      end
    end
    if (cal_we && int'(cal_sel) < NUM_MOT) cal_m[cal_sel] = sx(cal_data);
    if (in_valid && int'(mot_sel_in) < NUM_MOT) begin
      e.ch = int'(mot_sel_in);
      e.diff = longint'(bemf_adc_h) - longint'(bemf_adc_l);
      e.vel = 0;
      e.edge_n = edge_cnt;
      q.push_back(e);
    end
  endtask

  task automatic compare();
    chk("out_valid", longint'(out_valid), longint'(m_valid));
    chk("bemf_out", sx(bemf_out), m_out);
    chk("bemf_vel_out", sx(bemf_vel_out), m_vel);
    chk("mot_sel_out", longint'(mot_sel_out), longint'(m_sel));
    chk("sat_out", longint'(sat_out), longint'(m_sat));
  endtask

  // One clock cycle: model the edge, drive new inputs, compare mid-cycle.
  task automatic step(input bit v, input int ch, input int h, input int l,
                      input bit cwe, input int csel, input longint cdata,
                      input logic [NUM_MOT-1:0] clr, input bit rn);
    @(posedge clk);
    model_edge();
    #1;
    in_valid   = v;
    mot_sel_in = SEL_W'(ch);
    bemf_adc_h = ADC_W'(h);
    bemf_adc_l = ADC_W'(l);
    cal_we     = cwe;
    cal_sel    = SEL_W'(csel);
    cal_data   = ACC_W'(cdata);
    acc_clr    = clr;
    rst_n      = rn;
    if (!rst_n) model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int ch, input int h, input int l);
    step(1, ch, h, l, 0, 0, 0, '0, 1);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, '0, 1);
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask
  task automatic calw(input int ch, input longint d);
    step(0, 0, 0, 0, 1, ch, d, '0, 1);
  endtask
  task automatic clr_step(input logic [NUM_MOT-1:0] c);
    step(0, 0, 0, 0, 0, 0, 0, c, 1);
  endtask
  task automatic rst_step();
    step(0, 0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    longint cd;
    checks = 0;
    errors = 0;
    in_valid = 0; mot_sel_in = '0; bemf_adc_h = '0; bemf_adc_l = '0;
    cal_we = 0; cal_sel = '0; cal_data = '0; acc_clr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    rst_step();
    rst_step();
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset bemf_out", sx(bemf_out), 0);

    // Plain sample on channel 1.
    send(1, 600, 100);
    idle_n(4);
    chk("t1 out_valid", longint'(out_valid), 1);
    chk("t1 mot_sel", longint'(mot_sel_out), 1);
    chk("t1 vel", sx(bemf_vel_out), 500);
    chk("t1 bemf_out", sx(bemf_out), 500);

    // Calibration into and out of the deadband.
    calw(2, 480);
    send(2, 600, 100);
    idle_n(4);
    chk("t2 vel deadband", sx(bemf_vel_out), 0);
    chk("t2 bemf_out", sx(bemf_out), 0);
    calw(2, -30);
    send(2, 600, 100);
    idle_n(4);
    chk("t2 vel 530", sx(bemf_vel_out), 530);
    chk("t2 bemf_out 530", sx(bemf_out), 530);

    // Back-to-back chaining on channel 0.
    for (int i = 0; i < 4; i++) send(0, 0, 1000);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t3 chain", sx(bemf_out), -1000 * longint'(i + 1));
    end

    // Clear colliding with an S3 update of the same channel.
    send(0, 600, 100);
    idle_n(2);
    clr_step(4'b0001);
    idle();
    chk("t5 valid", longint'(out_valid), 1);
    chk("t5 bemf_out", sx(bemf_out), 0);
    chk("t5 vel", sx(bemf_vel_out), 500);
    chk("t5 sat", longint'(sat_out), 0);
    send(0, 600, 100);
    idle_n(4);
    chk("t5 after clear", sx(bemf_out), 500);

    // Positive saturation via a large calibration offset.
    calw(3, -300000);
    for (int i = 0; i < 3; i++) send(3, 600, 100);
    idle();
    idle();
    chk("sat 1st out", sx(bemf_out), 300500);
    chk("sat 1st flag", longint'(sat_out), 0);
    idle();
    chk("sat 2nd out", sx(bemf_out), AMAX);
    chk("sat 2nd flag", longint'(sat_out), 1);
    idle();
    chk("sat 3rd flag", longint'(sat_out), 1);

    // Reset with samples in flight.
    calw(1, -30);
    for (int i = 0; i < 3; i++) send(1, 600, 100);
    rst_step();
    chk("t6 reset vel", sx(bemf_vel_out), 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("t6 no valid", longint'(out_valid), 0);
    end
    for (int k = 0; k < NUM_MOT; k++) send(k, 600, 100);
    for (int k = 0; k < NUM_MOT; k++) begin
      idle();
      chk("t6 fresh bemf_out", sx(bemf_out), 500);
      chk("t6 fresh vel", sx(bemf_vel_out), 500);
    end

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_step();
      end else begin
        if ($urandom_range(0, 3) == 0)
          cd = longint'($urandom_range(200000, 400000)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
        else
          cd = longint'($urandom_range(0, 1200)) - 600;
        step($urandom_range(0, 3) != 0,
             int'($urandom_range(0, NUM_MOT - 1)),
             int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1023)),
             $urandom_range(0, 15) == 0,
             int'($urandom_range(0, NUM_MOT - 1)),
             cd,
             ($urandom_range(0, 23) == 0) ? NUM_MOT'($urandom) : '0,
             1);
      end
    end
    idle_n(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
